fetch_queue: RTL and testbench

- Instruction fetch stage that sits directly upstream of the decoder.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers them in a small FIFO.
- Presents instruction+PC pairs downstream with a valid/ready handshake. Branch/jump redirects flush the queue and discard in-flight responses.

---
 rtl/fetch_queue.sv | 170 +++++++++++++++++
 tb/tb_fetch_queue.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential request issue, in-order response buffering, redirect flush.
// Optional same-cycle response bypass to the decoder when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int unsigned     PC_W     = 10,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [PC_W-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [PC_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t state, state_next;

    logic [PC_W-1:0] fetch_pc, fetch_pc_next;
    logic [CW-1:0]   outstanding, outstanding_next;
    logic [CW-1:0]   drop_cnt, drop_cnt_next;
    logic [CW-1:0]   count, count_next;
    logic [CW-1:0]   credit_used, inflight;
    logic [AW-1:0]   head, tail, tq_rd, tq_wr;

    logic [31:0]     fifo_data [DEPTH];
    logic [PC_W-1:0] fifo_pc   [DEPTH];
    logic [PC_W-1:0] tag_q     [DEPTH];

    logic fifo_empty, req_fire, rsp_take, fifo_push, fifo_pop, bypass_hit;

    // Handshake and datapath control
    always_comb begin
        fifo_empty     = (count == '0);
        credit_used    = count + outstanding;
        imem_req_valid = !reset && (state == RUN) && !redirect && (credit_used < CW'(DEPTH));
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_take       = !reset && !redirect && (state == RUN) && imem_rsp_valid
                         && (outstanding != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit     = rsp_take && fifo_empty;
`else
        bypass_hit     = 1'b0;
`endif
        instr_valid    = !reset && (!fifo_empty || bypass_hit);
        fifo_pop       = !reset && !redirect && !fifo_empty && instr_ready;
        // A bypassed response consumed this cycle never occupies a slot
        fifo_push      = rsp_take && !(bypass_hit && instr_ready);

        instr    = '0;
        instr_pc = '0;
        if (!reset) begin
            if (!fifo_empty) begin
                instr    = fifo_data[head];
                instr_pc = fifo_pc[head];
            end else if (bypass_hit) begin
                instr    = imem_rsp_data;
                instr_pc = tag_q[tq_rd];
            end
        end
    end

    // Next-state and counters
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        outstanding_next = outstanding;
        drop_cnt_next    = drop_cnt;
        count_next       = count;
        // Only one of outstanding/drop_cnt is non-zero at a time
        inflight         = outstanding + drop_cnt;

        if (redirect) begin
            fetch_pc_next    = {redirect_pc[PC_W-1:2], 2'b00};
            outstanding_next = '0;
            count_next       = '0;
            if (imem_rsp_valid && (inflight != '0)) begin
                drop_cnt_next = inflight - CW'(1);
            end else begin
                drop_cnt_next = inflight;
            end
            state_next = (drop_cnt_next != '0) ? FLUSH : RUN;
        end else begin
            case (state)
                RUN: begin
                    outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_take);
                end
                FLUSH: begin
                    if (imem_rsp_valid && (drop_cnt != '0)) begin
                        drop_cnt_next = drop_cnt - CW'(1);
                        if (drop_cnt == CW'(1)) begin
                            state_next = RUN;
                        end
                    end
                end
                default: state_next = RUN;
            endcase
            if (req_fire) begin
                fetch_pc_next = fetch_pc + PC_W'(4);
            end
            count_next = count + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            tq_rd       <= '0;
            tq_wr       <= '0;
        end else begin
            fetch_pc    <= fetch_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
            count       <= count_next;
            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                tq_rd <= '0;
                tq_wr <= '0;
            end else begin
                if (fifo_push) begin
                    fifo_data[tail] <= imem_rsp_data;
                    fifo_pc[tail]   <= tag_q[tq_rd];
                    tail            <= tail + AW'(1);
                end
                if (fifo_pop) begin
                    head <= head + AW'(1);
                end
                if (req_fire) begin
                    tag_q[tq_wr] <= fetch_pc;
                    tq_wr        <= tq_wr + AW'(1);
                end
                if (rsp_take) begin
                    tq_rd <= tq_rd + AW'(1);
                end
            end
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model plus a PC scoreboard
// filled at request issue and drained as the decoder side consumes instructions.
module tb_fetch_queue;
    localparam int unsigned PC_W  = 10;
    localparam int unsigned DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   imem_req_valid, imem_req_ready;
    logic [PC_W-1:0]        imem_req_addr;
    logic                   imem_rsp_valid;
    logic [31:0]            imem_rsp_data;
    logic                   redirect;
    logic [PC_W-1:0]        redirect_pc;
    logic                   instr_valid, instr_ready;
    logic [31:0]            instr;
    logic [PC_W-1:0]        instr_pc;
    logic [$clog2(DEPTH):0] occupancy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mem_lat = 1;
    int last_due = 0;
    bit use_override = 1'b0;
    logic [31:0] override_data = 32'h0;

    logic [PC_W-1:0] pend_addr[$];
    int              pend_due[$];
    logic [PC_W-1:0] exp_pc_q[$];

    bit              took, fired;
    logic [PC_W-1:0] got_pc, faddr, e;
    logic [31:0]     got_data;

    fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(10'h000)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return {12'hC0D, a, a};
    endfunction

    function automatic bit sb_pop(output logic [PC_W-1:0] ev);
        if (exp_pc_q.size() == 0) begin
            ev = 'x;
            return 1'b0;
        end
        ev = exp_pc_q.pop_front();
        return 1'b1;
    endfunction

    // One clock: called at a falling edge with control inputs already set, returns at the next one.
    task automatic step();
        int due;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = use_override ? override_data : mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        took     = instr_valid && instr_ready && !redirect && !reset;
        got_pc   = instr_pc;
        got_data = instr;
        fired    = imem_req_valid && imem_req_ready;
        faddr    = imem_req_addr;
        if (fired) begin
            due = cyc + mem_lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(due);
            exp_pc_q.push_back(imem_req_addr);
        end
        if (redirect || reset) exp_pc_q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        exp_pc_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        instr_ready = 1'b1; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        @(negedge clk);
        step();
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr); end
        n_cmp++; if (instr_pc !== '0) begin n_bad++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        step();
        reset = 1'b0;
        pend_addr.delete(); pend_due.delete(); exp_pc_q.delete();
        #1;
        n_cmp++; if (occupancy !== '0) begin n_bad++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_req: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 10'h000) begin n_bad++; $display("FAIL rst_first_addr: got %h want 000", imem_req_addr); end
    endtask

    task automatic test_sequential();
        logic [PC_W-1:0] ea = '0;
        int ntook = 0;
        mem_lat = 1; instr_ready = 1'b1; imem_req_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (fired) begin
                n_cmp++;
                if (faddr !== ea) begin n_bad++; $display("FAIL seq_addr: got %h want %h", faddr, ea); end
                ea = ea + 10'd4;
            end
            if (took) begin
                ntook++;
                n_cmp++;
                if (!sb_pop(e) || got_pc !== e || got_data !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL seq_sb: got pc=%h data=%h want pc=%h data=%h", got_pc, got_data, e, mem_word(e));
                end
            end
            n_cmp++;
            if (occupancy > 3'(DEPTH)) begin n_bad++; $display("FAIL seq_occ: got %0d want <= %0d", occupancy, DEPTH); end
        end
        n_cmp++;
        if (ntook != 28) begin n_bad++; $display("FAIL seq_throughput: got %0d want 28", ntook); end
    endtask

    task automatic test_backpressure();
        int nfire = 0;
        int first_fire = -1;
        do_reset(1);
        mem_lat = 1; instr_ready = 1'b0; imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (fired) nfire++;
        end
        n_cmp++; if (nfire != 4) begin n_bad++; $display("FAIL bp_issued: got %0d want 4", nfire); end
        #1;
        n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL bp_occ: got %0d want 4", occupancy); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (fired && first_fire < 0) begin
                first_fire = i;
                n_cmp++;
                if (faddr !== 10'h010) begin n_bad++; $display("FAIL bp_resume_addr: got %h want 010", faddr); end
            end
            if (took) begin
                n_cmp++;
                if (!sb_pop(e) || got_pc !== e || got_data !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL bp_sb: got pc=%h data=%h want pc=%h data=%h", got_pc, got_data, e, mem_word(e));
                end
            end
        end
        n_cmp++; if (first_fire != 1) begin n_bad++; $display("FAIL bp_resume_cycle: got %0d want 1", first_fire); end
    endtask

    task automatic test_redirect_inflight();
        int nfire = 0;
        int k = -1;
        int ntook = 0;
        do_reset(1);
        mem_lat = 4; instr_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (3) begin
            step();
            if (fired) nfire++;
        end
        n_cmp++; if (nfire != 3) begin n_bad++; $display("FAIL rd_outstanding: got %0d want 3", nfire); end
        redirect = 1'b1; redirect_pc = 10'h123;
        step();
        redirect = 1'b0;
        n_cmp++; if (fired !== 1'b0) begin n_bad++; $display("FAIL rd_req_in_redirect: got %b want 0", fired); end
        for (int i = 1; i <= 10; i++) begin
            step();
            if (fired) begin
                k = i;
                n_cmp++;
                if (faddr !== 10'h120) begin n_bad++; $display("FAIL rd_new_addr: got %h want 120", faddr); end
                break;
            end
        end
        n_cmp++; if (k != 4) begin n_bad++; $display("FAIL rd_resume_cycle: got %0d want 4", k); end
        for (int i = 0; i < 12 && ntook == 0; i++) begin
            step();
            if (took) begin
                ntook++;
                n_cmp++;
                if (!sb_pop(e) || got_pc !== 10'h120 || e !== 10'h120 || got_data !== mem_word(10'h120)) begin
                    n_bad++;
                    $display("FAIL rd_first_instr: got pc=%h data=%h want pc=120 data=%h", got_pc, got_data, mem_word(10'h120));
                end
            end
        end
        n_cmp++; if (ntook != 1) begin n_bad++; $display("FAIL rd_timeout: got %0d instrs want 1", ntook); end
    endtask

    task automatic test_redirect_coincident();
        int ntook = 0;
        do_reset(1);
        mem_lat = 2; instr_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (6) begin
            step();
            if (took) begin
                n_cmp++;
                if (!sb_pop(e) || got_pc !== e || got_data !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL rc_pre_sb: got pc=%h data=%h want pc=%h", got_pc, got_data, e);
                end
            end
        end
        redirect = 1'b1; redirect_pc = 10'h0A6;
        step();
        redirect = 1'b0;
        #1;
        n_cmp++; if (occupancy !== '0) begin n_bad++; $display("FAIL rc_occ: got %0d want 0", occupancy); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rc_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rc_flush_req: got %b want 0", imem_req_valid); end
        step();
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'h0A4) begin
            n_bad++; $display("FAIL rc_resume: got valid=%b addr=%h want valid=1 addr=0a4", imem_req_valid, imem_req_addr);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (took) begin
                ntook++;
                n_cmp++;
                if (!sb_pop(e) || got_pc !== e || got_data !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL rc_post_sb: got pc=%h data=%h want pc=%h data=%h", got_pc, got_data, e, mem_word(e));
                end
            end
        end
        n_cmp++; if (ntook == 0) begin n_bad++; $display("FAIL rc_no_progress: got 0 instrs want >0"); end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] got_a [4];
        logic [PC_W-1:0] want_a [4];
        int n = 0;
        want_a[0] = 10'h3F8; want_a[1] = 10'h3FC; want_a[2] = 10'h000; want_a[3] = 10'h004;
        for (int i = 0; i < 4; i++) got_a[i] = 'x;
        mem_lat = 1;
        redirect = 1'b1; redirect_pc = 10'h3F8;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (fired && n < 4) begin
                got_a[n] = faddr;
                n++;
            end
            if (took) begin
                n_cmp++;
                if (!sb_pop(e) || got_pc !== e || got_data !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL wrap_sb: got pc=%h data=%h want pc=%h data=%h", got_pc, got_data, e, mem_word(e));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_a[i] !== want_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, got_a[i], want_a[i]); end
        end
    endtask

    task automatic test_reset_in_flush();
        logic [PC_W-1:0] ea = '0;
        do_reset(1);
        mem_lat = 4; instr_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 10'h200;
        step();
        redirect = 1'b0;
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        n_cmp++; if (pend_due.size() != 0) begin n_bad++; $display("FAIL rf_late_rsp: got %0d pending want 0", pend_due.size()); end
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'h000) begin
            n_bad++; $display("FAIL rf_restart: got valid=%b addr=%h want valid=1 addr=000", imem_req_valid, imem_req_addr);
        end
        n_cmp++; if (occupancy !== '0 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL rf_empty: got occ=%0d valid=%b want occ=0 valid=0", occupancy, instr_valid);
        end
        mem_lat = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (fired) begin
                n_cmp++;
                if (faddr !== ea) begin n_bad++; $display("FAIL rf_addr: got %h want %h", faddr, ea); end
                ea = ea + 10'd4;
            end
            if (took) begin
                n_cmp++;
                if (!sb_pop(e) || got_pc !== e || got_data !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL rf_sb: got pc=%h data=%h want pc=%h data=%h", got_pc, got_data, e, mem_word(e));
                end
            end
        end
    endtask

    task automatic test_bypass();
        do_reset(1);
        mem_lat = 1; instr_ready = 1'b1; imem_req_ready = 1'b1;
        use_override = 1'b1; override_data = 32'hDEADBEEF;
        step();
        imem_req_ready = 1'b0;
        n_cmp++; if (fired !== 1'b1) begin n_bad++; $display("FAIL byp_issue: got %b want 1", fired); end
        step();
`ifdef FETCH_QUEUE_BYPASS_EN
        n_cmp++;
        if (took !== 1'b1 || !sb_pop(e) || got_data !== 32'hDEADBEEF || got_pc !== 10'h000) begin
            n_bad++; $display("FAIL byp_same_cycle: got valid=%b data=%h pc=%h want valid=1 data=deadbeef pc=000", took, got_data, got_pc);
        end
        #1;
        n_cmp++; if (occupancy !== '0) begin n_bad++; $display("FAIL byp_occ: got %0d want 0", occupancy); end
`else
        n_cmp++; if (took !== 1'b0) begin n_bad++; $display("FAIL nobyp_comb_path: got valid=%b want 0", took); end
        #1;
        n_cmp++; if (occupancy !== 3'd1) begin n_bad++; $display("FAIL nobyp_occ: got %0d want 1", occupancy); end
        step();
        n_cmp++;
        if (took !== 1'b1 || !sb_pop(e) || got_data !== 32'hDEADBEEF || got_pc !== 10'h000) begin
            n_bad++; $display("FAIL nobyp_out: got valid=%b data=%h pc=%h want valid=1 data=deadbeef pc=000", took, got_data, got_pc);
        end
        #1;
        n_cmp++; if (occupancy !== '0) begin n_bad++; $display("FAIL nobyp_drain: got %0d want 0", occupancy); end
`endif
        use_override = 1'b0;
        imem_req_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_wrap();
        test_reset_in_flush();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
